// File: rtl/cpu_run_checker.sv
// Run controller for the CPU under test: holds it in reset, lets it run, then freezes it
// and scans its register file against an expected table. Optional feature: HALT_INPUT_EN adds a halt input.
module cpu_run_checker #(
  parameter int DATA_W       = 32,
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int RESET_CYCLES = 4,
  parameter int RUN_CYCLES   = 15,
  parameter int CNT_W        = 16,
  parameter int READ_LAT     = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              cpu_reset,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              exp_mask,
`ifdef HALT_INPUT_EN
  input  logic              halt,
`endif
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(RUN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   ISSUE_LAST = (ADDR_W + 1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   CYC_LAST   = (ADDR_W + 1)'(NUM_REGS + READ_LAT - 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    hold_cnt;
  logic [ADDR_W:0]     chk_cyc;
  logic                halt_now;
  logic                hold_end;
  logic                run_end;
  logic                check_end;
  logic                issue;
  logic                cmp_valid;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [DATA_W-1:0]   cmp_exp;
  logic                cmp_mask;
  logic                mismatch;
  logic [ADDR_W:0]     err_next;

`ifdef HALT_INPUT_EN
  assign halt_now = halt;
`else
  assign halt_now = 1'b0;
`endif

  assign fsm_state = state;

  assign hold_end  = (state == S_HOLD) && (hold_cnt == HOLD_LAST);
  assign run_end   = (state == S_RUN) && ((cycle_cnt == RUN_LAST) || halt_now);
  assign check_end = (state == S_CHECK) && (chk_cyc == CYC_LAST);
  // An address is issued on each of the first NUM_REGS CHECK cycles only.
  assign issue     = (state == S_CHECK) && (chk_cyc <= ISSUE_LAST);

  // Compare stage: same cycle as the address, or one cycle behind it.
  generate
    if (READ_LAT == 0) begin : g_lat0
      assign cmp_valid = issue;
      assign cmp_addr  = chk_addr;
      assign cmp_exp   = exp_data;
      assign cmp_mask  = exp_mask;
    end else begin : g_lat1
      logic              p_valid;
      logic [ADDR_W-1:0] p_addr;
      logic [DATA_W-1:0] p_exp;
      logic              p_mask;

      // Expected data is registered with the address so it lines up with reg_rdata.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          p_valid <= 1'b0;
          p_addr  <= '0;
          p_exp   <= '0;
          p_mask  <= 1'b0;
        end else begin
          p_valid <= issue;
          p_addr  <= chk_addr;
          p_exp   <= exp_data;
          p_mask  <= exp_mask;
        end
      end

      assign cmp_valid = p_valid;
      assign cmp_addr  = p_addr;
      assign cmp_exp   = p_exp;
      assign cmp_mask  = p_mask;
    end
  endgenerate

  assign mismatch = cmp_valid && cmp_mask && (reg_rdata != cmp_exp);
  assign err_next = err_count + {{ADDR_W{1'b0}}, mismatch};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_HOLD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HOLD:  if (hold_end)  state_next = S_RUN;
      S_RUN:   if (run_end)   state_next = S_CHECK;
      S_CHECK: if (check_end) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_HOLD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt       <= '0;
      chk_cyc        <= '0;
      cpu_reset      <= 1'b0;
      cpu_stall      <= 1'b0;
      chk_addr       <= '0;
      cycle_cnt      <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_end) begin
            cpu_reset <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (run_end) begin
            cpu_stall <= 1'b1;
            chk_addr  <= '0;
            chk_cyc   <= '0;
          end
        end
        S_CHECK: begin
          // Address parks on the last register; it never wraps.
          if (chk_addr != ADDR_LAST) begin
            chk_addr <= chk_addr + 1'b1;
          end
          chk_cyc   <= chk_cyc + 1'b1;
          err_count <= err_next;
          if (mismatch && (err_count == '0)) begin
            first_err_addr <= cmp_addr;
          end
          if (check_end) begin
            done <= 1'b1;
            pass <= (err_next == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_checker.sv
// Bench for cpu_run_checker: one READ_LAT=0 instance with a combinational register file and one
// READ_LAT=1 instance with a registered register file, both driven from the same tables.
module tb_cpu_run_checker;

  localparam int DW      = 32;
  localparam int NR      = 32;
  localparam int AW      = 5;
  localparam int CW      = 16;
  localparam int RST_CYC = 4;
  localparam int RUN_CYC = 15;
  localparam int RW      = AW + 1 + AW + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- register file and expected table ----------------
  logic [DW-1:0] regs    [NR];
  logic [DW-1:0] exp_tab [NR];
  logic          mask_tab[NR];
`ifdef HALT_INPUT_EN
  logic halt;
`endif

  logic          cpu_reset0, cpu_stall0, done0, pass0, expm0;
  logic [AW-1:0] chk_addr0, first0;
  logic [AW:0]   err0;
  logic [CW-1:0] cc0;
  logic [1:0]    st0;
  logic [DW-1:0] rdata0, expd0;

  logic          cpu_reset1, cpu_stall1, done1, pass1, expm1;
  logic [AW-1:0] chk_addr1, first1;
  logic [AW:0]   err1;
  logic [CW-1:0] cc1;
  logic [1:0]    st1;
  logic [DW-1:0] rdata1, expd1;

  assign rdata0 = regs[chk_addr0];
  assign expd0  = exp_tab[chk_addr0];
  assign expm0  = mask_tab[chk_addr0];
  assign expd1  = exp_tab[chk_addr1];
  assign expm1  = mask_tab[chk_addr1];
  always @(posedge clock) rdata1 <= regs[chk_addr1];

  cpu_run_checker #(.READ_LAT(0)) dut0 (
    .clock(clock), .reset(reset),
    .cpu_reset(cpu_reset0), .cpu_stall(cpu_stall0), .chk_addr(chk_addr0),
    .reg_rdata(rdata0), .exp_data(expd0), .exp_mask(expm0),
`ifdef HALT_INPUT_EN
    .halt(halt),
`endif
    .cycle_cnt(cc0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_addr(first0), .fsm_state(st0)
  );

  cpu_run_checker #(.READ_LAT(1)) dut1 (
    .clock(clock), .reset(reset),
    .cpu_reset(cpu_reset1), .cpu_stall(cpu_stall1), .chk_addr(chk_addr1),
    .reg_rdata(rdata1), .exp_data(expd1), .exp_mask(expm1),
`ifdef HALT_INPUT_EN
    .halt(halt),
`endif
    .cycle_cnt(cc1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_addr(first1), .fsm_state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  int tests_run    = 0;
  int tests_failed = 0;

  // Packed expectation {err_count, first_err_addr, pass} from the tables.
  function automatic logic [RW-1:0] model();
    logic [AW:0]   cnt;
    logic [AW-1:0] first;
    cnt   = '0;
    first = '0;
    for (int i = 0; i < NR; i++) begin
      if (mask_tab[i] && (exp_tab[i] !== regs[i])) begin
        if (cnt == 0) first = AW'(i);
        cnt = cnt + 1'b1;
      end
    end
    return {cnt, first, (cnt == 0)};
  endfunction

  task automatic load_identity();
    for (int i = 0; i < NR; i++) begin
      regs[i]     = DW'(i);
      exp_tab[i]  = DW'(i);
      mask_tab[i] = 1'b1;
    end
  endtask

  // Full HOLD->RUN->CHECK->DONE pass on both instances with phase timing checks.
  task automatic run_and_check(input string tag, input int halt_at);
    int run_len, t_rel, t_stall, t_done0, t_done1;
    logic [RW-1:0] e;
    run_len = (halt_at > 0) ? halt_at : RUN_CYC;
    t_rel = -1; t_stall = -1; t_done0 = -1; t_done1 = -1;
    exp_q0.push_back(model());
    exp_q1.push_back(model());
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clock); #1;
      if (cpu_reset0 && t_rel < 0) t_rel = c;
      if (cpu_stall0 && t_stall < 0) t_stall = c;
      if (done0 && t_done0 < 0) begin
        t_done0 = c;
        e = exp_q0.pop_front();
        tests_run++;
        if ({err0, first0, pass0} !== e) begin
          tests_failed++;
          $display("FAIL %s result_lat0: got err=%0d first=%0d pass=%0b want err=%0d first=%0d pass=%0b",
                   tag, err0, first0, pass0, e[RW-1:AW+1], e[AW:1], e[0]);
        end
      end
      if (done1 && t_done1 < 0) begin
        t_done1 = c;
        e = exp_q1.pop_front();
        tests_run++;
        if ({err1, first1, pass1} !== e) begin
          tests_failed++;
          $display("FAIL %s result_lat1: got err=%0d first=%0d pass=%0b want err=%0d first=%0d pass=%0b",
                   tag, err1, first1, pass1, e[RW-1:AW+1], e[AW:1], e[0]);
        end
      end
`ifdef HALT_INPUT_EN
      halt = (halt_at > 0) && cpu_reset0 && !cpu_stall0 && (cc0 == CW'(halt_at - 1));
`endif
      if (t_done0 >= 0 && t_done1 >= 0) break;
    end
`ifdef HALT_INPUT_EN
    halt = 1'b0;
`endif
    tests_run++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      tests_failed++;
      $display("FAIL %s no_done: got done0=%0b done1=%0b want both 1", tag, done0, done1);
      exp_q0.delete();
      exp_q1.delete();
    end
    tests_run++;
    if (t_rel !== RST_CYC) begin
      tests_failed++;
      $display("FAIL %s hold_len: got %0d want %0d", tag, t_rel, RST_CYC);
    end
    tests_run++;
    if (t_stall !== RST_CYC + run_len) begin
      tests_failed++;
      $display("FAIL %s stall_edge: got %0d want %0d", tag, t_stall, RST_CYC + run_len);
    end
    tests_run++;
    if (t_done0 !== RST_CYC + run_len + NR) begin
      tests_failed++;
      $display("FAIL %s done_edge_lat0: got %0d want %0d", tag, t_done0, RST_CYC + run_len + NR);
    end
    tests_run++;
    if (t_done1 !== RST_CYC + run_len + NR + 1) begin
      tests_failed++;
      $display("FAIL %s done_edge_lat1: got %0d want %0d", tag, t_done1, RST_CYC + run_len + NR + 1);
    end
    tests_run++;
    if (cc0 !== CW'(run_len) || cc1 !== CW'(run_len)) begin
      tests_failed++;
      $display("FAIL %s cycle_cnt: got %0d/%0d want %0d", tag, cc0, cc1, run_len);
    end
    // dut0 finished a cycle earlier, so this also checks that DONE is sticky.
    tests_run++;
    if ({done0, cpu_reset0, cpu_stall0, chk_addr0, st0} !== {3'b111, AW'(NR - 1), 2'd3} ||
        {done1, cpu_reset1, cpu_stall1, chk_addr1, st1} !== {3'b111, AW'(NR - 1), 2'd3}) begin
      tests_failed++;
      $display("FAIL %s done_state: got addr=%0d/%0d st=%0d/%0d rst=%0b stall=%0b want addr=%0d st=3",
               tag, chk_addr0, chk_addr1, st0, st1, cpu_reset0, cpu_stall0, NR - 1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    load_identity();
    reset = 1'b0;
    #1;
    tests_run++;
    if ({cpu_reset0, cpu_stall0, chk_addr0, cc0, done0, pass0, err0, first0, st0} !== '0) begin
      tests_failed++;
      $display("FAIL reset_lat0: got rst=%0b stall=%0b addr=%0d cc=%0d done=%0b err=%0d st=%0d want all 0",
               cpu_reset0, cpu_stall0, chk_addr0, cc0, done0, err0, st0);
    end
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({cpu_reset1, cpu_stall1, chk_addr1, cc1, done1, pass1, err1, first1, st1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_lat1: got rst=%0b stall=%0b addr=%0d cc=%0d done=%0b err=%0d st=%0d want all 0",
               cpu_reset1, cpu_stall1, chk_addr1, cc1, done1, err1, st1);
    end
  endtask

  task automatic test_all_match();
    load_identity();
    run_and_check("all_match", 0);
  endtask

  task automatic test_two_errors();
    load_identity();
    exp_tab[7]  = 32'hDEAD_0007;
    exp_tab[20] = 32'h0000_0021;
    run_and_check("two_errors", 0);
  endtask

  task automatic test_masked();
    load_identity();
    exp_tab[7]  = 32'hDEAD_0007;
    exp_tab[20] = 32'h0000_0021;
    mask_tab[7] = 1'b0;
    run_and_check("masked", 0);
  endtask

  task automatic test_last_reg();
    load_identity();
    exp_tab[31] = 32'h8000_001F;
    run_and_check("last_reg", 0);
  endtask

  task automatic test_first_reg();
    load_identity();
    regs[0] = 32'h0000_0100;
    run_and_check("first_reg", 0);
  endtask

  task automatic test_reset_mid_check();
    logic hit;
    load_identity();
    exp_tab[3]  = 32'h1234_5678;
    exp_tab[25] = 32'h0;
    hit = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clock); #1;
      if (cpu_stall0 && chk_addr0 == AW'(10)) begin
        hit = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!hit || err0 !== 6'd1 || first0 !== 5'd3) begin
      tests_failed++;
      $display("FAIL mid_check_pre: got hit=%0b err=%0d first=%0d want hit=1 err=1 first=3", hit, err0, first0);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({cpu_reset0, cpu_stall0, chk_addr0, cc0, done0, pass0, err0, first0, st0} !== '0 ||
        {cpu_reset1, cpu_stall1, chk_addr1, cc1, done1, pass1, err1, first1, st1} !== '0) begin
      tests_failed++;
      $display("FAIL mid_check_async: got rst=%0b stall=%0b addr=%0d/%0d err=%0d/%0d st=%0d/%0d want all 0",
               cpu_reset0, cpu_stall0, chk_addr0, chk_addr1, err0, err1, st0, st1);
    end
    run_and_check("after_mid_reset", 0);
  endtask

  task automatic test_random();
    int nerr;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < NR; i++) begin
        regs[i]     = $urandom;
        exp_tab[i]  = regs[i];
        mask_tab[i] = ($urandom_range(0, 7) != 0);
      end
      nerr = $urandom_range(0, 4);
      for (int k = 0; k < nerr; k++) begin
        exp_tab[$urandom_range(0, NR - 1)] ^= DW'(1) << $urandom_range(0, DW - 1);
      end
      run_and_check("random", 0);
    end
  endtask

`ifdef HALT_INPUT_EN
  task automatic test_halt();
    load_identity();
    exp_tab[12] = 32'h0;
    run_and_check("halt_at_6", 6);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef HALT_INPUT_EN
    halt = 1'b0;
`endif
    test_reset();
    test_all_match();
    test_two_errors();
    test_masked();
    test_last_reg();
    test_first_reg();
    test_reset_mid_check();
    test_random();
`ifdef HALT_INPUT_EN
    test_halt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
